morse_message_controller: RTL and testbench



---
 rtl/morse_message_controller.sv | 112 +++++++++++
 tb/tb_morse_message_controller.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/morse_message_controller.sv
// morse_message_controller: queues letter codes and shifts each Morse pattern out one symbol slot at a time,
// followed by a fixed run of dark gap slots.
module morse_message_controller #(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int SYMBOL_CYCLES = CLOCK_FREQUENCY / 2,
  parameter int GAP_SYMBOLS = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         ClockIn,
  input  logic                         Resetn,
  input  logic                         Clear,
  input  logic                         LetterValid,
  input  logic [2:0]                   Letter,
  output logic                         LetterReady,
  output logic                         DotDashOut,
  output logic                         NewBitOut,
  output logic                         Busy,
  output logic [$clog2(FIFO_DEPTH):0]  FifoCount
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = SYMBOL_CYCLES > 1 ? $clog2(SYMBOL_CYCLES) : 1;
  localparam int GW = GAP_SYMBOLS > 1 ? $clog2(GAP_SYMBOLS) : 1;
  localparam logic [DW-1:0] DIV_TOP = DW'(SYMBOL_CYCLES - 1);
  localparam logic [GW-1:0] GAP_TOP = GW'(GAP_SYMBOLS - 1);
  localparam logic [11:0] PAT [8] = '{12'hB80, 12'hEA8, 12'hEBA, 12'hEA0,
                                      12'h800, 12'hAE8, 12'hEE8, 12'hAA0};
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;
  state_t state_q, state_d;
  logic [2:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [11:0] shreg_q, shreg_d;
  logic [3:0] bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic [GW-1:0] gap_q, gap_d;
  logic full, push, pop, slot_end;
  assign full = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign LetterReady = Resetn & ~full;
  assign push = LetterValid & LetterReady & ~Clear;
  assign pop = state_q == LOAD;
  assign slot_end = div_q == '0;
  assign DotDashOut = state_q == SHIFT && shreg_q[11];
  assign NewBitOut = state_q == SHIFT && div_q == DIV_TOP;
  assign Busy = state_q != IDLE || cnt_q != '0;
  assign FifoCount = cnt_q;
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d = bit_q;
    div_d = div_q;
    gap_d = gap_q;
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    case (state_q)
      IDLE: state_d = cnt_q != '0 ? LOAD : IDLE;
      LOAD: begin
        shreg_d = PAT[mem_q[rd_q]];
        bit_d = 4'd11;
        div_d = DIV_TOP;
        state_d = SHIFT;
      end
      SHIFT: begin
        div_d = slot_end ? DIV_TOP : div_q - DW'(1);
        state_d = slot_end && bit_q == '0 ? GAP : SHIFT;
        gap_d = slot_end && bit_q == '0 ? GAP_TOP : gap_q;
        shreg_d = slot_end && bit_q != '0 ? shreg_q << 1 : shreg_q;
        bit_d = slot_end && bit_q != '0 ? bit_q - 4'd1 : bit_q;
      end
      GAP: begin
        // the final gap slot leaves divcnt at zero rather than reloading it
        state_d = slot_end && gap_q == '0 ? IDLE : GAP;
        div_d = !slot_end ? div_q - DW'(1) : gap_q == '0 ? div_q : DIV_TOP;
        gap_d = slot_end && gap_q != '0 ? gap_q - GW'(1) : gap_q;
      end
    endcase
    if (Clear) begin
      state_d = IDLE;
      wr_d = '0;
      rd_d = '0;
      cnt_d = '0;
      shreg_d = '0;
      bit_d = '0;
      div_d = '0;
      gap_d = '0;
    end
  end
  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      shreg_q <= '0;
      bit_q <= '0;
      div_q <= '0;
      gap_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      shreg_q <= shreg_d;
      bit_q <= bit_d;
      div_q <= div_d;
      gap_q <= gap_d;
    end
  end
  always_ff @(posedge ClockIn) begin
    if (push) mem_q[wr_q] <= Letter;
  end
endmodule

// File: tb/tb_morse_message_controller.sv
// tb_morse_message_controller: table-driven letter vectors, directed corner sequences and a random run
// checked every cycle against a timeline model of letter occupancy.
module tb_morse_message_controller;
  localparam int SC = 4, GS = 3, FD = 4, LAST = 12 * SC + GS * SC;
  typedef struct {logic [2:0] l; logic [11:0] pat; int fall;} vec_t;
  logic clk = 0, rst_n = 1, clear = 0, lv = 0;
  logic [2:0] letter = 0;
  logic ready, ddo, nbo, busy;
  logic [2:0] cnt;
  int errors = 0, checks = 0, cyc = 0;
  logic [11:0] pats [8];
  vec_t tbl [8];
  int q[$];
  int phase = -1, cur = 0;
  always #5 clk = ~clk;
  morse_message_controller #(.CLOCK_FREQUENCY(8), .SYMBOL_CYCLES(SC), .GAP_SYMBOLS(GS), .FIFO_DEPTH(FD)) dut (
    .ClockIn(clk), .Resetn(rst_n), .Clear(clear), .LetterValid(lv), .Letter(letter),
    .LetterReady(ready), .DotDashOut(ddo), .NewBitOut(nbo), .Busy(busy), .FifoCount(cnt));
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // model: phase -1 idle, 0 load, 1..12*SC symbol slots, then GS*SC gap cycles
  function automatic int m_ddo();
    if (phase < 1 || phase > 12 * SC) return 0;
    return int'(pats[cur][11 - (phase - 1) / SC]);
  endfunction
  function automatic int m_nbo();
    return int'(phase >= 1 && phase <= 12 * SC && (phase - 1) % SC == 0);
  endfunction
  task automatic step(input logic v, input logic [2:0] l, input logic c);
    int n;
    @(negedge clk);
    cyc++;
    chk("ready", ready, int'(q.size() < FD));
    chk("dotdash", ddo, m_ddo());
    chk("newbit", nbo, m_nbo());
    chk("busy", busy, int'(phase != -1 || q.size() != 0));
    chk("count", cnt, q.size());
    lv = v;
    letter = l;
    clear = c;
    n = q.size();
    if (c) begin
      q.delete();
      phase = -1;
    end else begin
      if (phase == 0) cur = q.pop_front();
      phase = phase == -1 ? (n > 0 ? 0 : -1) : phase == LAST ? -1 : phase + 1;
      if (v && n < FD) q.push_back(int'(l));
    end
  endtask
  initial begin
    int pulses, acc, nb, maxc, prev, rate;
    int starts[$];
    bit saw;
    pats = '{12'hB80, 12'hEA8, 12'hEBA, 12'hEA0, 12'h800, 12'hAE8, 12'hEE8, 12'hAA0};
    tbl = '{'{3'd0, 12'b1011_1000_0000, 62}, '{3'd1, 12'b1110_1010_1000, 62},
            '{3'd2, 12'b1110_1011_1010, 62}, '{3'd3, 12'b1110_1010_0000, 62},
            '{3'd4, 12'b1000_0000_0000, 62}, '{3'd5, 12'b1010_1110_1000, 62},
            '{3'd6, 12'b1110_1110_1000, 62}, '{3'd7, 12'b1010_1010_0000, 62}};
    #1 rst_n = 0;
    #11;
    chk("rst_ready", ready, 0);
    chk("rst_ddo", ddo, 0);
    chk("rst_nbo", nbo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", cnt, 0);
    @(negedge clk);
    rst_n = 1;
    step(0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      pulses = 0;
      step(1, tbl[i].l, 0);
      for (int r = 0; r < 64; r++) begin
        step(0, 0, 0);
        if (r >= 2 && r < 2 + 12 * SC)
          chk($sformatf("pat%0d_r%0d", i, r), ddo, int'(tbl[i].pat[11 - (r - 2) / SC]));
        pulses += int'(nbo);
        if (r == tbl[i].fall - 1) chk("busy_before_fall", busy, 1);
        if (r == tbl[i].fall) chk("busy_fall", busy, 0);
      end
      chk("pulses", pulses, 12);
    end
    acc = 0;
    nb = 0;
    maxc = 0;
    for (int k = 0; k < 340; k++) begin
      step(acc < 5, 3'(acc), 0);
      if (cnt == 3'd4) chk("full_not_ready", ready, 0);
      if (int'(cnt) > maxc) maxc = int'(cnt);
      if (nbo) begin
        if (nb % 12 == 0) starts.push_back(k);
        nb++;
      end
      if (lv && ready) acc++;
    end
    chk("b2b_accepted", acc, 5);
    chk("b2b_max_ge3", int'(maxc >= 3), 1);
    chk("b2b_letters", starts.size(), 5);
    for (int j = 1; j < starts.size(); j++) chk("b2b_spacing", starts[j] - starts[j-1], 62);
    saw = 0;
    prev = 0;
    for (int k = 0; k < 150; k++) begin
      step(1, 3'($urandom_range(0, 7)), 0);
      if (prev == 4 && cnt != 3'd4) begin
        saw = 1;
        chk("full_pop_dec", cnt, 3);
      end
      prev = int'(cnt);
    end
    chk("full_pop_seen", int'(saw), 1);
    step(0, 0, 1);
    step(1, 3'd6, 0);
    step(1, 3'd0, 0);
    step(1, 3'd1, 0);
    repeat (10) step(0, 0, 0);
    chk("clr_pre_busy", busy, 1);
    chk("clr_pre_count", cnt, 2);
    step(0, 0, 1);
    chk("clr_pre_ddo", ddo, 1);
    step(1, 3'd7, 0);
    chk("clr_ddo", ddo, 0);
    chk("clr_busy", busy, 0);
    chk("clr_count", cnt, 0);
    step(0, 0, 0);
    chk("h_idle_nbo", nbo, 0);
    step(0, 0, 0);
    chk("h_load_nbo", nbo, 0);
    step(0, 0, 0);
    chk("h_start_nbo", nbo, 1);
    chk("h_start_ddo", ddo, 1);
    repeat (70) step(0, 0, 0);
    step(1, 3'd4, 0);
    repeat (53) step(0, 0, 0);
    chk("gap_busy_pre", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_ddo", ddo, 0);
    chk("arst_nbo", nbo, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", ready, 0);
    chk("arst_count", cnt, 0);
    q.delete();
    phase = -1;
    repeat (2) @(negedge clk);
    rst_n = 1;
    step(0, 0, 0);
    chk("post_rst_ready", ready, 1);
    chk("post_rst_count", cnt, 0);
    rate = 30;
    for (int k = 0; k < 4000; k++) begin
      if (k % 500 == 0) rate = $urandom_range(1, 60);
      step($urandom_range(0, 99) < rate, 3'($urandom_range(0, 7)), $urandom_range(0, 399) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
